// File: rtl/taxi_gt_apb_seq_pkg.sv
// Shared types for the GT control-port APB sequencer: command opcodes,
// FSM states and the latched command record.
package taxi_gt_apb_seq_pkg;

  localparam int APB_ADDR_W = 18;
  localparam int APB_DATA_W = 16;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_RMW   = 2'd2
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    MODIFY,
    RESP
  } state_t;

  typedef struct packed {
    op_t                   op;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] data;
    logic [APB_DATA_W-1:0] mask;
  } cmd_t;

  // Encoding 3 is reserved and behaves as a plain read.
  function automatic op_t decode_op(input logic [1:0] raw);
    case (raw)
      2'd1:    return OP_WRITE;
      2'd2:    return OP_RMW;
      default: return OP_READ;
    endcase
  endfunction

endpackage

// File: rtl/taxi_gt_apb_seq_if.sv
// Command stream, response stream and APB requester bus of the sequencer.
// master = sequencer side, slave = command source / APB completer side.
interface taxi_gt_apb_seq_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  localparam int STRB_W = DATA_W / 8;

  logic              s_cmd_valid;
  logic              s_cmd_ready;
  logic [1:0]        s_cmd_op;
  logic [ADDR_W-1:0] s_cmd_addr;
  logic [DATA_W-1:0] s_cmd_data;
  logic [DATA_W-1:0] s_cmd_mask;

  logic              m_rsp_valid;
  logic              m_rsp_ready;
  logic [DATA_W-1:0] m_rsp_data;
  logic              m_rsp_err;
  logic              m_rsp_timeout;

  logic              m_apb_psel;
  logic              m_apb_penable;
  logic              m_apb_pwrite;
  logic [ADDR_W-1:0] m_apb_paddr;
  logic [DATA_W-1:0] m_apb_pwdata;
  logic [STRB_W-1:0] m_apb_pstrb;
  logic              m_apb_pready;
  logic [DATA_W-1:0] m_apb_prdata;
  logic              m_apb_pslverr;

  modport master (
    input  s_cmd_valid, s_cmd_op, s_cmd_addr, s_cmd_data, s_cmd_mask,
    output s_cmd_ready,
    output m_rsp_valid, m_rsp_data, m_rsp_err, m_rsp_timeout,
    input  m_rsp_ready,
    output m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata, m_apb_pstrb,
    input  m_apb_pready, m_apb_prdata, m_apb_pslverr
  );

  modport slave (
    output s_cmd_valid, s_cmd_op, s_cmd_addr, s_cmd_data, s_cmd_mask,
    input  s_cmd_ready,
    input  m_rsp_valid, m_rsp_data, m_rsp_err, m_rsp_timeout,
    output m_rsp_ready,
    input  m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata, m_apb_pstrb,
    output m_apb_pready, m_apb_prdata, m_apb_pslverr
  );

endinterface

// File: rtl/taxi_gt_apb_seq.sv
// APB requester for the GT DRP control port: runs READ/WRITE/RMW commands as
// one or two APB transfers. Optional ACCESS timeout: GT_APB_SEQ_TIMEOUT_EN.
module taxi_gt_apb_seq
  import taxi_gt_apb_seq_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  taxi_gt_apb_seq_if.master   bus,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;

  state_t            state_reg, state_next;
  cmd_t              cmd_reg, cmd_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              wr_phase_reg, wr_phase_next;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
  logic              rsp_err_reg, rsp_err_next;
  logic              is_write;

`ifdef GT_APB_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  cnt_reg;
  logic              rsp_timeout_reg, rsp_timeout_next;
  logic              cnt_expired;

  assign cnt_expired = (cnt_reg == CNT_W'(TIMEOUT - 1));

  // Cleared in SETUP so every ACCESS (read or write phase) starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg         <= '0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      rsp_timeout_reg <= rsp_timeout_next;
      if (state_reg == SETUP)
        cnt_reg <= '0;
      else if (state_reg == ACCESS && !bus.m_apb_pready)
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bus.m_rsp_timeout = rsp_timeout_reg;
`else
  assign bus.m_rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cmd_reg      <= '0;
      wdata_reg    <= '0;
      wr_phase_reg <= 1'b0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cmd_reg      <= cmd_next;
      wdata_reg    <= wdata_next;
      wr_phase_reg <= wr_phase_next;
      rsp_data_reg <= rsp_data_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cmd_next      = cmd_reg;
    wdata_next    = wdata_reg;
    wr_phase_next = wr_phase_reg;
    rsp_data_next = rsp_data_reg;
    rsp_err_next  = rsp_err_reg;
`ifdef GT_APB_SEQ_TIMEOUT_EN
    rsp_timeout_next = rsp_timeout_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (bus.s_cmd_valid) begin
          cmd_next.op   = decode_op(bus.s_cmd_op);
          cmd_next.addr = bus.s_cmd_addr;
          cmd_next.data = bus.s_cmd_data;
          cmd_next.mask = bus.s_cmd_mask;
          wdata_next    = bus.s_cmd_data;
          wr_phase_next = 1'b0;
          rsp_data_next = '0;
          rsp_err_next  = 1'b0;
`ifdef GT_APB_SEQ_TIMEOUT_EN
          rsp_timeout_next = 1'b0;
`endif
          state_next    = SETUP;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (bus.m_apb_pready) begin
          rsp_err_next = rsp_err_reg | bus.m_apb_pslverr;
          if (cmd_reg.op == OP_RMW && !wr_phase_reg) begin
            // A failed read leaves the target untouched and reports what came back.
            rsp_data_next = bus.m_apb_prdata;
            state_next    = bus.m_apb_pslverr ? RESP : MODIFY;
          end else begin
            rsp_data_next = (cmd_reg.op == OP_READ) ? bus.m_apb_prdata : wdata_reg;
            state_next    = RESP;
          end
        end
`ifdef GT_APB_SEQ_TIMEOUT_EN
        else if (cnt_expired) begin
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
          rsp_data_next    = '0;
          state_next       = RESP;
        end
`endif
      end
      MODIFY: begin
        wdata_next    = (rsp_data_reg & ~cmd_reg.mask) | (cmd_reg.data & cmd_reg.mask);
        wr_phase_next = 1'b1;
        state_next    = SETUP;
      end
      RESP: begin
        if (bus.m_rsp_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign is_write = (cmd_reg.op == OP_WRITE) || (cmd_reg.op == OP_RMW && wr_phase_reg);

  // APB outputs decode straight from state so reset drops psel without waiting a clock.
  assign bus.s_cmd_ready   = (state_reg == IDLE) && !rst;
  assign bus.m_apb_psel    = (state_reg == SETUP) || (state_reg == ACCESS);
  assign bus.m_apb_penable = (state_reg == ACCESS);
  assign bus.m_apb_pwrite  = bus.m_apb_psel && is_write;
  assign bus.m_apb_paddr   = cmd_reg.addr;
  assign bus.m_apb_pwdata  = bus.m_apb_pwrite ? wdata_reg : '0;
  assign bus.m_apb_pstrb   = bus.m_apb_pwrite ? {STRB_W{1'b1}} : '0;

  assign bus.m_rsp_valid = (state_reg == RESP);
  assign bus.m_rsp_data  = rsp_data_reg;
  assign bus.m_rsp_err   = rsp_err_reg;

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_taxi_gt_apb_seq.sv
// Directed bench for taxi_gt_apb_seq; expectations follow the macro
// GT_APB_SEQ_TIMEOUT_EN seen by the build.
module tb_taxi_gt_apb_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   vectors = 0;
  int   miscompares = 0;

  taxi_gt_apb_seq_if ifc ();

  taxi_gt_apb_seq #(.TIMEOUT(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifc),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [1:0] op, input logic [17:0] addr,
                         input logic [15:0] data, input logic [15:0] mask);
    ifc.s_cmd_valid = 1'b1;
    ifc.s_cmd_op    = op;
    ifc.s_cmd_addr  = addr;
    ifc.s_cmd_data  = data;
    ifc.s_cmd_mask  = mask;
  endtask

  task automatic test_reset();
    ifc.s_cmd_valid = 1'b0; ifc.s_cmd_op = 2'd0; ifc.s_cmd_addr = '0;
    ifc.s_cmd_data = '0; ifc.s_cmd_mask = '0; ifc.m_rsp_ready = 1'b0;
    ifc.m_apb_pready = 1'b0; ifc.m_apb_prdata = '0; ifc.m_apb_pslverr = 1'b0;
    #12;
    vectors++;
    if ({ifc.s_cmd_ready, ifc.m_apb_psel, ifc.m_apb_penable, ifc.m_apb_pwrite, ifc.m_rsp_valid,
         ifc.m_rsp_err, ifc.m_rsp_timeout, busy} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b exp 00000000", {ifc.s_cmd_ready, ifc.m_apb_psel,
               ifc.m_apb_penable, ifc.m_apb_pwrite, ifc.m_rsp_valid, ifc.m_rsp_err,
               ifc.m_rsp_timeout, busy});
    end
    vectors++;
    if ({ifc.m_apb_paddr, ifc.m_apb_pwdata, ifc.m_apb_pstrb, ifc.m_rsp_data} !== 52'h0) begin
      miscompares++;
      $display("FAIL reset_data got %h exp 0", {ifc.m_apb_paddr, ifc.m_apb_pwdata,
               ifc.m_apb_pstrb, ifc.m_rsp_data});
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    vectors++;
    if (ifc.s_cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready got %b exp 1", ifc.s_cmd_ready);
    end
  endtask

  task automatic test_write();
    ifc.m_rsp_ready = 1'b1;
    ifc.m_apb_pready = 1'b1;
    set_cmd(2'd1, 18'h0_0123, 16'hBEEF, 16'h0000);
    vectors++;
    if (ifc.s_cmd_ready !== 1'b1 || ifc.m_apb_psel !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_c0 got ready=%b psel=%b exp 1 0", ifc.s_cmd_ready, ifc.m_apb_psel);
    end
    step();
    ifc.s_cmd_valid = 1'b0;
    vectors++;
    if ({ifc.m_apb_psel, ifc.m_apb_penable, ifc.m_apb_pwrite, ifc.m_apb_paddr, ifc.m_apb_pwdata}
        !== {3'b101, 18'h0_0123, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL wr_setup got psel=%b pen=%b pw=%b a=%h d=%h exp 1 0 1 00123 beef",
               ifc.m_apb_psel, ifc.m_apb_penable, ifc.m_apb_pwrite, ifc.m_apb_paddr, ifc.m_apb_pwdata);
    end
    step();
    vectors++;
    if ({ifc.m_apb_psel, ifc.m_apb_penable, ifc.m_apb_pstrb, ifc.m_apb_pwdata} !== {4'b1111, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL wr_access got psel=%b pen=%b strb=%b d=%h exp 1 1 11 beef",
               ifc.m_apb_psel, ifc.m_apb_penable, ifc.m_apb_pstrb, ifc.m_apb_pwdata);
    end
    step();
    vectors++;
    if ({ifc.m_rsp_valid, ifc.m_rsp_err, ifc.m_apb_psel, ifc.m_rsp_data} !== {3'b100, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL wr_rsp got v=%b err=%b psel=%b d=%h exp 1 0 0 beef",
               ifc.m_rsp_valid, ifc.m_rsp_err, ifc.m_apb_psel, ifc.m_rsp_data);
    end
    step();
    ifc.m_apb_pready = 1'b0;
    vectors++;
    if ({ifc.m_rsp_valid, busy, ifc.s_cmd_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL wr_idle got v=%b busy=%b ready=%b exp 0 0 1", ifc.m_rsp_valid, busy, ifc.s_cmd_ready);
    end
  endtask

  task automatic test_read_wait();
    ifc.m_rsp_ready = 1'b1;
    ifc.m_apb_pready = 1'b0;
    set_cmd(2'd0, 18'h1_0040, 16'hFFFF, 16'h0000);
    step();
    ifc.s_cmd_valid = 1'b0;
    vectors++;
    if ({ifc.m_apb_psel, ifc.m_apb_pwrite, ifc.m_apb_pstrb, ifc.m_apb_pwdata, ifc.m_apb_paddr}
        !== {4'b1000, 16'h0000, 18'h1_0040}) begin
      miscompares++;
      $display("FAIL rd_setup got psel=%b pw=%b strb=%b d=%h a=%h exp 1 0 00 0000 10040",
               ifc.m_apb_psel, ifc.m_apb_pwrite, ifc.m_apb_pstrb, ifc.m_apb_pwdata, ifc.m_apb_paddr);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        ifc.m_apb_pready = 1'b1;
        ifc.m_apb_prdata = 16'h5A5A;
      end
      vectors++;
      if ({ifc.m_apb_psel, ifc.m_apb_penable, ifc.m_apb_pwrite, ifc.m_apb_paddr, ifc.m_apb_pstrb,
           ifc.m_apb_pwdata} !== {3'b110, 18'h1_0040, 2'b00, 16'h0000}) begin
        miscompares++;
        $display("FAIL rd_access_%0d got psel=%b pen=%b pw=%b a=%h strb=%b d=%h exp 1 1 0 10040 00 0000",
                 i, ifc.m_apb_psel, ifc.m_apb_penable, ifc.m_apb_pwrite, ifc.m_apb_paddr,
                 ifc.m_apb_pstrb, ifc.m_apb_pwdata);
      end
      step();
    end
    ifc.m_apb_pready = 1'b0;
    vectors++;
    if ({ifc.m_rsp_valid, ifc.m_rsp_err, ifc.m_rsp_data} !== {2'b10, 16'h5A5A}) begin
      miscompares++;
      $display("FAIL rd_rsp got v=%b err=%b d=%h exp 1 0 5a5a", ifc.m_rsp_valid, ifc.m_rsp_err, ifc.m_rsp_data);
    end
    step();
  endtask

  task automatic test_rmw();
    ifc.m_rsp_ready = 1'b1;
    ifc.m_apb_pready = 1'b1;
    ifc.m_apb_prdata = 16'hA5C3;
    set_cmd(2'd2, 18'h0_00FC, 16'h0300, 16'h0F00);
    step();
    ifc.s_cmd_valid = 1'b0;
    vectors++;
    if ({ifc.m_apb_psel, ifc.m_apb_pwrite} !== 2'b10) begin
      miscompares++;
      $display("FAIL rmw_rd_setup got psel=%b pw=%b exp 1 0", ifc.m_apb_psel, ifc.m_apb_pwrite);
    end
    step();
    step();
    vectors++;
    if ({ifc.m_apb_psel, busy, ifc.m_rsp_valid} !== 3'b010) begin
      miscompares++;
      $display("FAIL rmw_modify got psel=%b busy=%b v=%b exp 0 1 0", ifc.m_apb_psel, busy, ifc.m_rsp_valid);
    end
    step();
    vectors++;
    if ({ifc.m_apb_psel, ifc.m_apb_penable, ifc.m_apb_pwrite, ifc.m_apb_pstrb, ifc.m_apb_pwdata,
         ifc.m_apb_paddr} !== {5'b10111, 16'hA3C3, 18'h0_00FC}) begin
      miscompares++;
      $display("FAIL rmw_wr_setup got psel=%b pen=%b pw=%b strb=%b d=%h a=%h exp 1 0 1 11 a3c3 000fc",
               ifc.m_apb_psel, ifc.m_apb_penable, ifc.m_apb_pwrite, ifc.m_apb_pstrb,
               ifc.m_apb_pwdata, ifc.m_apb_paddr);
    end
    step();
    step();
    ifc.m_apb_pready = 1'b0;
    vectors++;
    if ({ifc.m_rsp_valid, ifc.m_rsp_err, ifc.m_rsp_data} !== {2'b10, 16'hA3C3}) begin
      miscompares++;
      $display("FAIL rmw_rsp got v=%b err=%b d=%h exp 1 0 a3c3", ifc.m_rsp_valid, ifc.m_rsp_err, ifc.m_rsp_data);
    end
    step();
  endtask

  task automatic test_rmw_err();
    ifc.m_rsp_ready = 1'b1;
    ifc.m_apb_pready = 1'b1;
    ifc.m_apb_pslverr = 1'b1;
    ifc.m_apb_prdata = 16'h1234;
    set_cmd(2'd2, 18'h0_0200, 16'hFFFF, 16'hFFFF);
    step();
    ifc.s_cmd_valid = 1'b0;
    step();
    step();
    vectors++;
    if ({ifc.m_apb_psel, ifc.m_rsp_valid, ifc.m_rsp_err, ifc.m_rsp_data} !== {3'b011, 16'h1234}) begin
      miscompares++;
      $display("FAIL rmw_err_rsp got psel=%b v=%b err=%b d=%h exp 0 1 1 1234",
               ifc.m_apb_psel, ifc.m_rsp_valid, ifc.m_rsp_err, ifc.m_rsp_data);
    end
    step();
    ifc.m_apb_pslverr = 1'b0;
    ifc.m_apb_pready = 1'b0;
    vectors++;
    if ({ifc.m_apb_psel, ifc.s_cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL rmw_err_idle got psel=%b ready=%b exp 0 1", ifc.m_apb_psel, ifc.s_cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    ifc.m_rsp_ready = 1'b0;
    ifc.m_apb_pready = 1'b1;
    set_cmd(2'd1, 18'h0_0055, 16'h1111, 16'h0000);
    step();
    set_cmd(2'd1, 18'h0_0066, 16'h2222, 16'h0000);
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({ifc.s_cmd_ready, ifc.m_rsp_valid, ifc.m_apb_psel, ifc.m_rsp_data} !== {3'b010, 16'h1111}) begin
        miscompares++;
        $display("FAIL b2b_hold_%0d got ready=%b v=%b psel=%b d=%h exp 0 1 0 1111",
                 i, ifc.s_cmd_ready, ifc.m_rsp_valid, ifc.m_apb_psel, ifc.m_rsp_data);
      end
      step();
    end
    ifc.m_rsp_ready = 1'b1;
    step();
    vectors++;
    if ({ifc.s_cmd_ready, ifc.m_rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_idle got ready=%b v=%b exp 1 0", ifc.s_cmd_ready, ifc.m_rsp_valid);
    end
    step();
    ifc.s_cmd_valid = 1'b0;
    vectors++;
    if ({ifc.m_apb_psel, ifc.m_apb_paddr, ifc.m_apb_pwdata} !== {1'b1, 18'h0_0066, 16'h2222}) begin
      miscompares++;
      $display("FAIL b2b_second_setup got psel=%b a=%h d=%h exp 1 00066 2222",
               ifc.m_apb_psel, ifc.m_apb_paddr, ifc.m_apb_pwdata);
    end
    step();
    step();
    ifc.m_apb_pready = 1'b0;
    vectors++;
    if ({ifc.m_rsp_valid, ifc.m_rsp_data} !== {1'b1, 16'h2222}) begin
      miscompares++;
      $display("FAIL b2b_second_rsp got v=%b d=%h exp 1 2222", ifc.m_rsp_valid, ifc.m_rsp_data);
    end
    step();
  endtask

  task automatic test_timeout();
    ifc.m_rsp_ready = 1'b1;
    ifc.m_apb_pready = 1'b0;
    set_cmd(2'd0, 18'h3_0000, 16'h0000, 16'h0000);
    step();
    ifc.s_cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if ({ifc.m_apb_psel, ifc.m_apb_penable, ifc.m_rsp_valid} !== 3'b110) begin
        miscompares++;
        $display("FAIL to_access_%0d got psel=%b pen=%b v=%b exp 1 1 0",
                 i, ifc.m_apb_psel, ifc.m_apb_penable, ifc.m_rsp_valid);
      end
      step();
    end
`ifdef GT_APB_SEQ_TIMEOUT_EN
    vectors++;
    if ({ifc.m_apb_psel, ifc.m_apb_penable, ifc.m_rsp_valid, ifc.m_rsp_err, ifc.m_rsp_timeout,
         ifc.m_rsp_data} !== {5'b00111, 16'h0000}) begin
      miscompares++;
      $display("FAIL to_rsp got psel=%b pen=%b v=%b err=%b to=%b d=%h exp 0 0 1 1 1 0000",
               ifc.m_apb_psel, ifc.m_apb_penable, ifc.m_rsp_valid, ifc.m_rsp_err,
               ifc.m_rsp_timeout, ifc.m_rsp_data);
    end
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL to_idle got busy=%b exp 0", busy);
    end
`else
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if ({ifc.m_rsp_valid, ifc.m_rsp_timeout, ifc.m_apb_penable} !== 3'b001) begin
        miscompares++;
        $display("FAIL to_wait_%0d got v=%b to=%b pen=%b exp 0 0 1",
                 i, ifc.m_rsp_valid, ifc.m_rsp_timeout, ifc.m_apb_penable);
      end
      step();
    end
`endif
  endtask

  task automatic test_reset_mid();
    ifc.m_rsp_ready = 1'b1;
    ifc.m_apb_pready = 1'b0;
`ifdef GT_APB_SEQ_TIMEOUT_EN
    set_cmd(2'd1, 18'h0_0777, 16'hCAFE, 16'h0000);
    step();
    ifc.s_cmd_valid = 1'b0;
    step();
    step();
`endif
    vectors++;
    if (ifc.m_apb_penable !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre got pen=%b exp 1", ifc.m_apb_penable);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({ifc.m_apb_psel, ifc.m_apb_penable, busy, ifc.m_rsp_valid, ifc.s_cmd_ready} !== 5'b0) begin
      miscompares++;
      $display("FAIL rstmid_drop got psel=%b pen=%b busy=%b v=%b ready=%b exp 0 0 0 0 0",
               ifc.m_apb_psel, ifc.m_apb_penable, busy, ifc.m_rsp_valid, ifc.s_cmd_ready);
    end
    ifc.m_apb_pready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({ifc.m_rsp_valid, ifc.m_apb_psel, busy, ifc.s_cmd_ready} !== 4'b0001) begin
        miscompares++;
        $display("FAIL rstmid_after_%0d got v=%b psel=%b busy=%b ready=%b exp 0 0 0 1",
                 i, ifc.m_rsp_valid, ifc.m_apb_psel, busy, ifc.s_cmd_ready);
      end
      step();
    end
    ifc.m_apb_pready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_rmw();
    test_rmw_err();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
